// File: rtl/multi_pulse_generator_pkg.sv
// multi_pulse_generator_pkg: shared state type and window-sum width helper
package multi_pulse_generator_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int sum_w(input int dly_w, input int wid_w);
    return (dly_w > wid_w ? dly_w : wid_w) + 1;
  endfunction
  localparam int SUM_W = sum_w(8, 4);
endpackage

// File: rtl/multi_pulse_generator_if.sv
// multi_pulse_generator_if: trigger, configuration and pulse output bundle
interface multi_pulse_generator_if #(
  parameter int N_CH  = 2,
  parameter int DLY_W = 8,
  parameter int WID_W = 4,
  parameter int REP_W = 8,
  parameter int PER_W = 16
);
  logic                    trigger;
  logic                    enable;
  logic                    retrig_en;
  logic [N_CH*DLY_W-1:0]   delay;
  logic [N_CH*WID_W-1:0]   width;
  logic [REP_W-1:0]        rep_count;
  logic [PER_W-1:0]        period;
  logic [N_CH-1:0]         pulse;
  logic                    busy;
  logic                    done;
  logic                    trig_overrun;
  modport master (
    output trigger, enable, retrig_en, delay, width, rep_count, period,
    input  pulse, busy, done, trig_overrun
  );
  modport slave (
    input  trigger, enable, retrig_en, delay, width, rep_count, period,
    output pulse, busy, done, trig_overrun
  );
endinterface

// File: rtl/multi_pulse_generator_pulse_window_cmp.sv
// pulse_window_cmp: tests delay <= t < delay + width at a width that cannot wrap
module pulse_window_cmp
  import multi_pulse_generator_pkg::*;
#(
  parameter int PER_W = 16,
  parameter int DLY_W = 8,
  parameter int WID_W = 4,
  parameter int SW    = SUM_W
) (
  input  logic [PER_W-1:0] t,
  input  logic [DLY_W-1:0] delay_i,
  input  logic [WID_W-1:0] width_i,
  output logic             in_window
);
  localparam int CW = PER_W > SW ? PER_W : SW;
  logic [SW-1:0] win_end;
  logic [CW-1:0] tw;
  // window end is one bit wider than either operand so it never overflows
  always_comb begin
    win_end   = SW'(delay_i) + SW'(width_i);
    tw        = CW'(t);
    in_window = (width_i != '0) && (tw >= CW'(delay_i)) && (tw < CW'(win_end));
  end
endmodule

// File: rtl/multi_pulse_generator.sv
// multi_pulse_generator: triggered bursts of per-channel delayed pulses
module multi_pulse_generator
  import multi_pulse_generator_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int DLY_W = 8,
  parameter int WID_W = 4,
  parameter int REP_W = 8,
  parameter int PER_W = 16
) (
  input logic clk,
  input logic rst,
  multi_pulse_generator_if.slave bus
);
  localparam int SW = sum_w(DLY_W, WID_W);
  logic                  s1, s2, s3;
  logic                  trig_rise;
  state_t                state;
  logic [PER_W-1:0]      t;
  logic [REP_W-1:0]      rep;
  logic [N_CH*DLY_W-1:0] dly_s;
  logic [N_CH*WID_W-1:0] wid_s;
  logic [REP_W-1:0]      rep_s;
  logic [PER_W-1:0]      per_s;
  logic [PER_W-1:0]      last_t;
  logic [REP_W-1:0]      last_rep;
  logic [N_CH-1:0]       in_win;
  assign trig_rise = s1 & s2 & ~s3;
  assign last_t    = per_s == '0 ? '0 : per_s - 1'b1;
  assign last_rep  = rep_s == '0 ? '0 : rep_s - 1'b1;
  assign bus.busy  = state == RUN;
  for (genvar i = 0; i < N_CH; i++) begin : g_cmp
    pulse_window_cmp #(.PER_W(PER_W), .DLY_W(DLY_W), .WID_W(WID_W), .SW(SW)) u_cmp (
      .t        (t),
      .delay_i  (dly_s[i*DLY_W +: DLY_W]),
      .width_i  (wid_s[i*WID_W +: WID_W]),
      .in_window(in_win[i])
    );
  end
  // three-flop trigger synchroniser; a rise needs two consecutive high samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.trigger;
      s2 <= s1;
      s3 <= s2;
    end
  end
  // sequence FSM: enable abort, then (re)start, then burst/period counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      t                <= '0;
      rep              <= '0;
      dly_s            <= '0;
      wid_s            <= '0;
      rep_s            <= '0;
      per_s            <= '0;
      bus.pulse        <= '0;
      bus.done         <= 1'b0;
      bus.trig_overrun <= 1'b0;
    end else begin
      bus.done         <= 1'b0;
      bus.trig_overrun <= 1'b0;
      bus.pulse        <= state == RUN ? in_win : '0;
      if (state == RUN && !bus.enable) begin
        state <= IDLE;
      end else if (trig_rise && bus.enable && (state == IDLE || bus.retrig_en)) begin
        state <= RUN;
        t     <= '0;
        rep   <= '0;
        dly_s <= bus.delay;
        wid_s <= bus.width;
        rep_s <= bus.rep_count;
        per_s <= bus.period;
      end else if (state == RUN) begin
        bus.trig_overrun <= trig_rise;
        if (t != last_t) begin
          t <= t + 1'b1;
        end else if (rep != last_rep) begin
          t   <= '0;
          rep <= rep + 1'b1;
        end else begin
          state    <= IDLE;
          bus.done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_pulse_generator.sv
// tb_multi_pulse_generator: directed and random checks against an elapsed-time model
module tb_multi_pulse_generator;
  localparam int N_CH = 2, DLY_W = 8, WID_W = 4, REP_W = 8, PER_W = 16;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  multi_pulse_generator_if #(.N_CH(N_CH), .DLY_W(DLY_W), .WID_W(WID_W), .REP_W(REP_W), .PER_W(PER_W)) bus ();
  multi_pulse_generator #(.N_CH(N_CH), .DLY_W(DLY_W), .WID_W(WID_W), .REP_W(REP_W), .PER_W(PER_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int checks = 0, failures = 0;
  bit run;
  int edge_n, start, hi_len, mp, mr;
  int md[N_CH], mw[N_CH];
  int hi_cnt[N_CH];
  int done_cnt, ovr_cnt;
  logic [N_CH-1:0] exp_pulse;
  logic exp_busy, exp_done, exp_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < N_CH; i++) hi_cnt[i] = 0;
    done_cnt = 0;
    ovr_cnt  = 0;
  endtask

  task automatic cfg(input logic [7:0] d0, input logic [7:0] d1, input logic [3:0] w0,
                     input logic [3:0] w1, input logic [7:0] rp, input logic [15:0] pr);
    bus.delay     = {d1, d0};
    bus.width     = {w1, w0};
    bus.rep_count = rp;
    bus.period    = pr;
  endtask

  // one clock: advance the model on the sampled inputs, then compare all outputs
  task automatic step();
    logic trg, en, ret;
    logic [N_CH*DLY_W-1:0] dl;
    logic [N_CH*WID_W-1:0] wd;
    logic [REP_W-1:0] rc;
    logic [PER_W-1:0] pr;
    bit rise;
    int e, t;
    trg = bus.trigger; en = bus.enable; ret = bus.retrig_en;
    dl = bus.delay; wd = bus.width; rc = bus.rep_count; pr = bus.period;
    @(posedge clk);
    edge_n++;
    rise = hi_len == 2;
    exp_pulse = '0; exp_done = 1'b0; exp_ovr = 1'b0;
    if (run) begin
      e = edge_n - 1 - start;
      t = e % mp;
      for (int i = 0; i < N_CH; i++)
        exp_pulse[i] = mw[i] != 0 && t >= md[i] && t < md[i] + mw[i];
      if (!en) run = 1'b0;
      else if (rise && ret) start = -1;
      else begin
        exp_ovr = rise;
        if (e == mr * mp - 1) begin run = 1'b0; exp_done = 1'b1; end
      end
    end else if (rise && en) begin
      run = 1'b1;
      start = -1;
    end
    if (start == -1) begin
      start = edge_n;
      for (int i = 0; i < N_CH; i++) begin
        md[i] = int'(dl[i*DLY_W +: DLY_W]);
        mw[i] = int'(wd[i*WID_W +: WID_W]);
      end
      mp = pr == 0 ? 1 : int'(pr);
      mr = rc == 0 ? 1 : int'(rc);
    end
    hi_len = trg ? hi_len + 1 : 0;
    exp_busy = run;
    #1;
    chk("pulse", 32'(bus.pulse), 32'(exp_pulse));
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    chk("done", 32'(bus.done), 32'(exp_done));
    chk("trig_overrun", 32'(bus.trig_overrun), 32'(exp_ovr));
    for (int i = 0; i < N_CH; i++) hi_cnt[i] += int'(bus.pulse[i]);
    done_cnt += int'(bus.done);
    ovr_cnt  += int'(bus.trig_overrun);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic trig(input int n);
    bus.trigger = 1'b1;
    repeat (n) step();
    bus.trigger = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_pulse", 32'(bus.pulse), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ovr", 32'(bus.trig_overrun), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run = 1'b0;
    hi_len = 0;
    edge_n = 0;
  endtask

  initial begin
    bus.trigger = 1'b0;
    bus.enable = 1'b1;
    bus.retrig_en = 1'b0;
    cfg(0, 0, 0, 0, 0, 0);
    run = 1'b0; edge_n = 0; start = 0; hi_len = 0; mp = 1; mr = 1;
    clr_cnt();
    do_reset();
    // basic two-channel sequence
    cfg(0, 5, 1, 1, 1, 10);
    clr_cnt(); trig(4); idle(14);
    chk("basic_ch0_cnt", hi_cnt[0], 1);
    chk("basic_ch1_cnt", hi_cnt[1], 1);
    chk("basic_done_cnt", done_cnt, 1);
    // repeated bursts
    cfg(2, 0, 3, 0, 3, 8);
    clr_cnt(); trig(2); idle(30);
    chk("rep_ch0_cnt", hi_cnt[0], 9);
    chk("rep_done_cnt", done_cnt, 1);
    // truncation and silent channel
    cfg(6, 0, 15, 0, 1, 10);
    clr_cnt(); trig(3); idle(15);
    chk("trunc_ch0_cnt", hi_cnt[0], 4);
    chk("silent_ch1_cnt", hi_cnt[1], 0);
    // retrigger restarts the run
    bus.retrig_en = 1'b1;
    cfg(0, 10, 5, 5, 1, 100);
    clr_cnt(); trig(2); idle(40); trig(2); idle(110);
    chk("retrig_done_cnt", done_cnt, 1);
    chk("retrig_ch0_cnt", hi_cnt[0], 10);
    chk("retrig_ovr_cnt", ovr_cnt, 0);
    // trigger ignored while running
    bus.retrig_en = 1'b0;
    clr_cnt(); trig(2); idle(40); trig(2); idle(110);
    chk("ovr_cnt", ovr_cnt, 1);
    chk("ovr_done_cnt", done_cnt, 1);
    chk("ovr_ch0_cnt", hi_cnt[0], 5);
    // enable abort
    cfg(10, 12, 3, 3, 1, 20);
    clr_cnt(); trig(2); idle(6);
    bus.enable = 1'b0; idle(3);
    bus.enable = 1'b1; idle(20);
    chk("abort_done_cnt", done_cnt, 0);
    // reset mid-pulse, then a fresh run
    cfg(0, 0, 8, 4, 1, 20);
    trig(2); idle(4);
    chk("pre_rst_pulse", 32'(bus.pulse), 32'd3);
    do_reset();
    clr_cnt(); trig(2); idle(25);
    chk("post_rst_ch0_cnt", hi_cnt[0], 8);
    chk("post_rst_done_cnt", done_cnt, 1);
    // one-cycle glitch is rejected
    clr_cnt(); trig(1); idle(10);
    chk("glitch_ch0_cnt", hi_cnt[0], 0);
    chk("glitch_done_cnt", done_cnt, 0);
    // inputs changed mid-run do not affect the latched run
    cfg(3, 0, 2, 0, 2, 10);
    clr_cnt(); trig(2); idle(3);
    cfg(0, 0, 9, 9, 5, 3);
    idle(30);
    chk("shadow_ch0_cnt", hi_cnt[0], 4);
    chk("shadow_ch1_cnt", hi_cnt[1], 0);
    chk("shadow_done_cnt", done_cnt, 1);
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(5) == 0) bus.trigger = ~bus.trigger;
      if ($urandom_range(29) == 0)
        cfg(8'($urandom_range(15)), 8'($urandom_range(15)), 4'($urandom_range(6)),
            4'($urandom_range(6)), 8'($urandom_range(3)), 16'($urandom_range(20)));
      if ($urandom_range(59) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(19) == 0) bus.retrig_en = 1'($urandom_range(1));
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
